// File: rtl/vector_mult_matrix_seq.sv
// rtl/vector_mult_matrix_seq.sv - sequential row-vector times matrix multiplier
//
// Computes y[j] = sum_i x[i]*A[i][j] (unsigned) one matrix row per cycle,
// using M parallel multipliers, with valid/ready handshakes on both sides.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    job presented on matrix_inp / vector_inp
//   in_ready    high in IDLE: a job is accepted on in_valid & in_ready
//   matrix_inp  N x M matrix, A[i][j] at DW*(i*M+j)
//   vector_inp  N-element vector, x[i] at DW*i
//   out_valid   high in DONE: outp holds a completed result
//   out_ready   downstream consumes the result
//   outp        M-element result, y[j] at OW*j
//   busy        high in RUN
module vector_mult_matrix_seq #(
  parameter int M  = 4,
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DW*N*M-1:0]               matrix_inp,
  input  logic [DW*N-1:0]                 vector_inp,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [(2*DW+$clog2(N))*M-1:0]   outp,
  output logic                            busy
);

  localparam int OW = 2*DW + $clog2(N);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2*DW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [RW-1:0]   row_q;
  logic [DW-1:0]   vec_q [N];
  logic [DW-1:0]   mat_q [N][M];
  logic [OW-1:0]   acc_q [M];
  logic [OW*M-1:0] outp_q;

  logic [PW-1:0]   prod  [M];
  logic [OW-1:0]   acc_d [M];
  logic [OW*M-1:0] outp_d;

  // One row of partial products per cycle; outp_d is the accumulator
  // state after this row, captured into outp_q only on the final row so
  // outp stays frozen while a new job accumulates.
  always_comb begin
    outp_d = '0;
    for (int j = 0; j < M; j++) begin
      prod[j]  = PW'(vec_q[row_q]) * PW'(mat_q[row_q][j]);
      acc_d[j] = acc_q[j] + OW'(prod[j]);
      outp_d[OW*j +: OW] = acc_d[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      outp_q  <= '0;
      for (int i = 0; i < N; i++) begin
        vec_q[i] <= '0;
        for (int j = 0; j < M; j++) begin
          mat_q[i][j] <= '0;
        end
      end
      for (int j = 0; j < M; j++) begin
        acc_q[j] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N; i++) begin
              vec_q[i] <= vector_inp[DW*i +: DW];
              for (int j = 0; j < M; j++) begin
                mat_q[i][j] <= matrix_inp[DW*(i*M+j) +: DW];
              end
            end
            for (int j = 0; j < M; j++) begin
              acc_q[j] <= '0;
            end
            row_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int j = 0; j < M; j++) begin
            acc_q[j] <= acc_d[j];
          end
          if (row_q == RW'(N-1)) begin
            outp_q  <= outp_d;
            state_q <= DONE;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign outp      = outp_q;

endmodule

// File: tb/tb_vector_mult_matrix_seq.sv
// tb/tb_vector_mult_matrix_seq.sv - self-checking bench for vector_mult_matrix_seq
module tb_vector_mult_matrix_seq;

  localparam int M  = 2;
  localparam int N  = 2;
  localparam int DW = 2;
  localparam int OW = 2*DW + $clog2(N);
  localparam int AW = DW*N*M;
  localparam int VW = DW*N;
  localparam int YW = OW*M;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] matrix_inp;
  logic [VW-1:0] vector_inp;
  logic          out_valid;
  logic          out_ready;
  logic [YW-1:0] outp;
  logic          busy;

  int checks;
  int errors;

  vector_mult_matrix_seq #(.M(M), .N(N), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .matrix_inp (matrix_inp),
    .vector_inp (vector_inp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .outp       (outp),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer dot products per output column.
  function automatic logic [YW-1:0] ref_y(input logic [AW-1:0] a, input logic [VW-1:0] v);
    logic [YW-1:0] y;
    int s;
    y = '0;
    for (int j = 0; j < M; j++) begin
      s = 0;
      for (int i = 0; i < N; i++) begin
        s += int'(v[DW*i +: DW]) * int'(a[DW*(i*M+j) +: DW]);
      end
      y[OW*j +: OW] = OW'(s);
    end
    return y;
  endfunction

  // Presents one job, waits (bounded) for out_valid; leaves the DUT in DONE.
  task automatic run_job(input logic [AW-1:0] a, input logic [VW-1:0] v,
                         output logic [YW-1:0] res, output int lat);
    matrix_inp = a;
    vector_inp = v;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = outp;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || outp !== '0) begin
      errors++;
      $display("FAIL reset: out_valid=%b busy=%b in_ready=%b outp=%0d expected 0 0 1 0",
               out_valid, busy, in_ready, outp);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: in_ready=%b busy=%b expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    logic [YW-1:0] res;
    int lat;
    run_job(8'hF9, 4'h9, res, lat);
    checks++;
    if (lat !== N) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected %0d", lat, N);
    end
    checks++;
    if (res !== 10'd263) begin
      errors++;
      $display("FAIL basic_result: got %0d expected 263", res);
    end
    release_out();
  endtask

  task automatic test_max();
    logic [YW-1:0] res;
    int lat;
    run_job('1, '1, res, lat);
    checks++;
    if (res !== 10'd594 || lat !== N) begin
      errors++;
      $display("FAIL max_result: got %0d lat %0d expected 594 lat %0d", res, lat, N);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    logic [YW-1:0] res;
    int lat;
    run_job(8'hF9, 4'h9, res, lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || outp !== 10'd263 || in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: cycle %0d out_valid=%b outp=%0d in_ready=%b busy=%b expected 1 263 0 0",
                 k, out_valid, outp, in_ready, busy);
      end
    end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || outp !== 10'd263) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b outp=%0d expected 0 1 263",
               out_valid, in_ready, outp);
    end
  endtask

  task automatic test_input_change();
    logic [YW-1:0] res;
    int lat;
    matrix_inp = 8'hF9;
    vector_inp = 4'h9;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      matrix_inp = AW'($urandom);
      vector_inp = VW'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    res = outp;
    checks++;
    if (res !== 10'd263 || lat !== N) begin
      errors++;
      $display("FAIL input_change: got %0d lat %0d expected 263 lat %0d", res, lat, N);
    end
    release_out();
  endtask

  task automatic test_reset_mid_run();
    logic [YW-1:0] res;
    int lat;
    logic seen;
    matrix_inp = '1;
    vector_inp = '1;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || outp !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: out_valid=%b busy=%b in_ready=%b outp=%0d expected 0 0 1 0",
               out_valid, busy, in_ready, outp);
    end
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: out_valid seen=%b expected 0", seen);
    end
    run_job(8'hF9, 4'h9, res, lat);
    checks++;
    if (res !== 10'd263 || lat !== N) begin
      errors++;
      $display("FAIL reset_next_job: got %0d lat %0d expected 263 lat %0d", res, lat, N);
    end
    release_out();
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [VW-1:0] v;
    logic [YW-1:0] res;
    logic [YW-1:0] exp_y;
    int lat;
    for (int k = 0; k < 12; k++) begin
      a = AW'($urandom);
      v = VW'($urandom);
      exp_y = ref_y(a, v);
      run_job(a, v, res, lat);
      checks++;
      if (res !== exp_y || lat !== N) begin
        errors++;
        $display("FAIL random_job %0d: a=%h v=%h got %0d lat %0d expected %0d lat %0d",
                 k, a, v, res, lat, exp_y, N);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    logic [YW-1:0] expq [$];
    logic [YW-1:0] exp_y;
    int cyc;
    int last_acc;
    int accepted;
    int results;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    matrix_inp = AW'($urandom);
    vector_inp = VW'($urandom);
    last_acc = -1;
    accepted = 0;
    results  = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        exp_y = (expq.size() > 0) ? expq.pop_front() : 'x;
        results++;
        checks++;
        if (outp !== exp_y) begin
          errors++;
          $display("FAIL b2b_result: got %0d expected %0d", outp, exp_y);
        end
      end
      if (in_ready) begin
        expq.push_back(ref_y(matrix_inp, vector_inp));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== N + 2) begin
            errors++;
            $display("FAIL b2b_interval: got %0d expected %0d", cyc - last_acc, N + 2);
          end
        end
        last_acc = cyc;
        accepted++;
      end
      @(posedge clk); #1;
      if (!in_ready) begin
        matrix_inp = AW'($urandom);
        vector_inp = VW'($urandom);
      end
    end
    in_valid  = 1'b0;
    checks++;
    if (accepted < 9 || results < 8) begin
      errors++;
      $display("FAIL b2b_count: accepted %0d results %0d expected at least 9 and 8", accepted, results);
    end
    repeat (N + 3) @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    matrix_inp = '0;
    vector_inp = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_input_change();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_mult_matrix_seq.md
VECTOR_MULT_MATRIX_SEQ -- requirements
Module: vector_mult_matrix_seq

Interface
REQ-001: Parameter M, default 4: number of matrix columns and output vector length.
REQ-002: Parameter N, default 4: number of matrix rows and input vector length.
REQ-003: Parameter DW, default 8: unsigned element width.
REQ-004: Localparam OW SHALL equal 2*DW + $clog2(N): result element width.
REQ-005: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006: rst  input  1  reset, synchronous and active-high.
REQ-007: in_valid  input  1  a job is presented on matrix_inp/vector_inp.
REQ-008: in_ready  output  1  block accepts a job this cycle.
REQ-009: matrix_inp  input  DW*N*M  flattened N x M matrix; element A[i][j] at bits [DW*(i*M+j)+DW-1 : DW*(i*M+j)].
REQ-010: vector_inp  input  DW*N  row vector x; x[i] at bits [DW*i+DW-1 : DW*i].
REQ-011: out_valid  output  1  outp holds a completed result.
REQ-012: out_ready  input  1  downstream consumes the result.
REQ-013: outp  output  OW*M  result y; y[j] at bits [OW*j+OW-1 : OW*j].
REQ-014: busy  output  1  high in RUN state.

Function
REQ-015: The block SHALL compute the row-vector-times-matrix product y[j] = sum over i of x[i]*A[i][j], unsigned, with no overflow or truncation at width OW.
REQ-016: FSM states SHALL be IDLE, RUN and DONE.
REQ-017: in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in RUN.
REQ-018: IDLE with in_valid=1 (handshake): the block SHALL register matrix_inp and vector_inp, clear all M accumulators and the row counter, and enter RUN.
REQ-019: IDLE with in_valid=0: the block SHALL remain in IDLE and hold all registers.
REQ-020: RUN, row counter r: the block SHALL perform acc[j] <= acc[j] + x[r]*A[r][j] for all j in parallel, using M multipliers.
REQ-021: RUN: if r = N-1, the block SHALL enter DONE; otherwise it SHALL increment r.
REQ-022: The row counter SHALL be max(1,$clog2(N)) bits wide; N=1 SHALL give exactly one RUN cycle.
REQ-023: Latency: for a handshake at edge t, out_valid SHALL rise after edge t+N.
REQ-024: Input ports SHALL be ignored outside the IDLE handshake; changes to them during RUN/DONE SHALL NOT affect the result.
REQ-025: DONE: outp SHALL be driven from the accumulators and held stable until the output handshake.
REQ-026: DONE with out_ready=1: the block SHALL enter IDLE; DONE with out_ready=0: it SHALL stay in DONE indefinitely.
REQ-027: After the output handshake, the next job SHALL be accepted no earlier than the following cycle; maximum throughput SHALL be one job per N+2 cycles.
REQ-028: outp SHALL hold its last value in IDLE and RUN; only out_valid qualifies it.

Reset
REQ-029: rst=1 at a clock edge SHALL force IDLE, clear the accumulators, row counter and captured operands, and give out_valid=0, busy=0, in_ready=1 and outp=0 after that edge.
REQ-030: rst SHALL take priority over all handshakes; a job in RUN or DONE SHALL be discarded without producing out_valid.

Verification (M=2, N=2, DW=2, OW=5)
REQ-031: Basic: vector_inp=4'h9 (x=[1,2]), matrix_inp=8'hF9 (A=[[1,2],[3,3]]) -> out_valid 2 cycles after the accepting edge, outp=10'd263 (y=[7,8]).
REQ-032: Maximum: all inputs all-ones -> outp=10'd594 (y=[18,18]), no overflow.
REQ-033: Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and outp stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-034: Input change: operands changed during RUN -> result still 263.
REQ-035: Reset mid-RUN: rst asserted 1 cycle after the handshake -> after the next edge IDLE, outp=0, no out_valid; the next job completes correctly.
REQ-036: Back-to-back: in_valid held high with out_ready=1 -> jobs accepted every N+2=4 cycles.
